// File: rtl/hazard_pipe_tracker_pkg.sv
// hazard_pkg: shared widths, zero-register number and pipeline destination record
package hazard_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } dest_t;
    localparam dest_t BUBBLE = '{rd: ZERO_REG, reg_write: 1'b0, mem_read: 1'b0};
endpackage

// File: rtl/hazard_pipe_tracker_if.sv
// hazard_pipe_tracker_if: decode-side inputs and hazard/forwarding outputs (HAZARD_STATS_EN adds counters)
interface hazard_pipe_tracker_if;
    import hazard_pkg::*;
    logic                  hold;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rn;
    logic [REG_ADDR_W-1:0] id_rm;
    logic                  id_uses_rm;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  stall;
    logic [REG_ADDR_W-1:0] idex_rd;
    logic                  idex_reg_write;
    logic                  idex_mem_read;
    logic [REG_ADDR_W-1:0] exmem_rd;
    logic                  exmem_reg_write;
    logic [REG_ADDR_W-1:0] memwb_rd;
    logic                  memwb_reg_write;
`ifdef HAZARD_STATS_EN
    logic [31:0]           stall_count;
    logic [31:0]           flush_count;
`endif
    modport master (
        output hold, flush, id_valid, id_rn, id_rm, id_uses_rm, id_rd, id_reg_write, id_mem_read,
        input  stall, idex_rd, idex_reg_write, idex_mem_read, exmem_rd, exmem_reg_write,
               memwb_rd, memwb_reg_write
`ifdef HAZARD_STATS_EN
        , input stall_count, flush_count
`endif
    );
    modport slave (
        input  hold, flush, id_valid, id_rn, id_rm, id_uses_rm, id_rd, id_reg_write, id_mem_read,
        output stall, idex_rd, idex_reg_write, idex_mem_read, exmem_rd, exmem_reg_write,
               memwb_rd, memwb_reg_write
`ifdef HAZARD_STATS_EN
        , output stall_count, flush_count
`endif
    );
endinterface

// File: rtl/hazard_pipe_tracker_dest_reg.sv
// pipe_dest_reg: one pipeline stage of destination metadata with hold and bubble injection
module pipe_dest_reg
    import hazard_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  i_hold,
    input  logic  i_bubble,
    input  dest_t i_d,
    output dest_t o_q
);
    dest_t r_q;
    // reset and bubble both load the empty record; hold freezes the stage
    always_ff @(posedge clk) begin
        if (reset)
            r_q <= BUBBLE;
        else if (!i_hold)
            r_q <= i_bubble ? BUBBLE : i_d;
    end
    assign o_q = r_q;
endmodule

// File: rtl/hazard_pipe_tracker.sv
// hazard_pipe_tracker: rd/RegWrite/MemRead tracking through ID/EX, EX/MEM, MEM/WB with load-use stall (HAZARD_STATS_EN adds counters)
module hazard_pipe_tracker
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    hazard_pipe_tracker_if.slave  bus
);
    dest_t w_id_d;
    dest_t w_idex;
    dest_t w_exmem;
    dest_t w_memwb;
    logic  w_stall;
    // decode fields become a record; writes to XZR are stored as non-writing
    always_comb begin
        w_id_d = bus.id_valid ? dest_t'{rd: bus.id_rd,
                                        reg_write: bus.id_reg_write & (bus.id_rd != ZERO_REG),
                                        mem_read: bus.id_mem_read} : BUBBLE;
        w_stall = bus.id_valid & w_idex.mem_read & (w_idex.rd != ZERO_REG)
                & ((w_idex.rd == bus.id_rn) | (bus.id_uses_rm & (w_idex.rd == bus.id_rm)));
    end
    pipe_dest_reg u_idex (
        .clk(clk), .reset(reset), .i_hold(bus.hold), .i_bubble(bus.flush | w_stall),
        .i_d(w_id_d), .o_q(w_idex)
    );
    pipe_dest_reg u_exmem (
        .clk(clk), .reset(reset), .i_hold(bus.hold), .i_bubble(1'b0),
        .i_d(w_idex), .o_q(w_exmem)
    );
    pipe_dest_reg u_memwb (
        .clk(clk), .reset(reset), .i_hold(bus.hold), .i_bubble(1'b0),
        .i_d(w_exmem), .o_q(w_memwb)
    );
    assign bus.stall           = w_stall;
    assign bus.idex_rd         = w_idex.rd;
    assign bus.idex_reg_write  = w_idex.reg_write;
    assign bus.idex_mem_read   = w_idex.mem_read;
    assign bus.exmem_rd        = w_exmem.rd;
    assign bus.exmem_reg_write = w_exmem.reg_write;
    assign bus.memwb_rd        = w_memwb.rd;
    assign bus.memwb_reg_write = w_memwb.reg_write;
`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;
    // count only honoured events: flush outranks stall, hold suppresses both; saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (!bus.hold) begin
            if (bus.flush && r_flush_count != 32'hFFFF_FFFF)
                r_flush_count <= r_flush_count + 32'd1;
            if (!bus.flush && w_stall && r_stall_count != 32'hFFFF_FFFF)
                r_stall_count <= r_stall_count + 32'd1;
        end
    end
    assign bus.stall_count = r_stall_count;
    assign bus.flush_count = r_flush_count;
`endif
endmodule
